// File: rtl/md_pkg.sv
// Shared types and constants for the HI/LO multiply/divide sequencer.
// Optional early-out divide is enabled with MD_EARLY_OUT_EN.
package md_pkg;

    localparam int XLEN      = 32;
    localparam int DIV_STEPS = 32;

    typedef enum logic [2:0] {
        MD_NONE = 3'd0,
        MD_MULT = 3'd1,
        MD_DIV  = 3'd2,
        MD_MTHI = 3'd3,
        MD_MTLO = 3'd4,
        MD_MFHI = 3'd5,
        MD_MFLO = 3'd6,
        MD_RSVD = 3'd7
    } md_func_t;

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        FIX
    } md_state_t;

    function automatic logic [XLEN-1:0] md_abs(
        input logic [XLEN-1:0] v,
        input logic            sgn
    );
        return (sgn && v[XLEN-1]) ? -v : v;
    endfunction

endpackage

// File: rtl/md_unit_ctrl_if.sv
// EX-stage <-> MD unit bundle: request fields in, stall/status/HI/LO out.
// master = pipeline side, slave = MD unit.
interface md_unit_ctrl_if;
    import md_pkg::*;

    logic            md_start;
    md_func_t        md_func;
    logic            md_sign;
    logic [XLEN-1:0] opa;
    logic [XLEN-1:0] opb;
    logic            ex_flush;
    logic            md_stall;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;

    modport master (
        output md_start, md_func, md_sign, opa, opb, ex_flush,
        input  md_stall, busy, done, hi, lo
    );

    modport slave (
        input  md_start, md_func, md_sign, opa, opb, ex_flush,
        output md_stall, busy, done, hi, lo
    );

endinterface

// File: rtl/md_div_step.sv
// One radix-2 restoring divide step; the controller iterates it.
module md_div_step
    import md_pkg::*;
(
    input  logic [XLEN:0]   rem,
    input  logic [XLEN-1:0] dvd,
    input  logic [XLEN-1:0] dsr,
    output logic [XLEN:0]   rem_nxt,
    output logic [XLEN-1:0] dvd_nxt,
    output logic            q_bit
);

    logic [XLEN+1:0] part;
    logic [XLEN+1:0] diff;

    always_comb begin
        part    = {rem, dvd[XLEN-1]};
        diff    = part - {2'b00, dsr};
        q_bit   = ~diff[XLEN+1];
        rem_nxt = q_bit ? diff[XLEN:0] : part[XLEN:0];
        dvd_nxt = {dvd[XLEN-2:0], 1'b0};
    end

endmodule

// File: rtl/md_unit_ctrl.sv
// HI/LO multiply/divide sequencer with pipeline stall generation.
// Define MD_EARLY_OUT_EN to finish divides with |opb| > |opa| early.
module md_unit_ctrl
    import md_pkg::*;
#(
    parameter int MUL_LAT = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    md_unit_ctrl_if.slave md
);

    md_state_t       state, nxt_state;
    logic [5:0]      cnt, nxt_cnt;
    logic [63:0]     prod, nxt_prod;
    logic [XLEN:0]   rem, nxt_rem;
    logic [XLEN-1:0] dvd, nxt_dvd;
    logic [XLEN-1:0] dsr, nxt_dsr;
    logic            neg_q, nxt_neg_q;
    logic            neg_r, nxt_neg_r;
    logic            dz, nxt_dz;
    logic [XLEN-1:0] hi_q, nxt_hi;
    logic [XLEN-1:0] lo_q, nxt_lo;
    logic            done_q, nxt_done;

    logic            busy;
    logic            func_ok;
    logic            accept;
    logic [XLEN-1:0] abs_a, abs_b;
    logic [63:0]     ext_a, ext_b;
    logic [XLEN:0]   step_rem;
    logic [XLEN-1:0] step_dvd;
    logic            step_q;

    assign busy    = (state != IDLE);
    assign func_ok = (md.md_func != MD_NONE) && (md.md_func != MD_RSVD);
    assign accept  = md.md_start && !md.ex_flush && !busy && func_ok;
    assign abs_a   = md_abs(md.opa, md.md_sign);
    assign abs_b   = md_abs(md.opb, md.md_sign);
    // Sign/zero extension lets one 64-bit multiply serve MULT and MULTU
    assign ext_a   = {{XLEN{md.md_sign & md.opa[XLEN-1]}}, md.opa};
    assign ext_b   = {{XLEN{md.md_sign & md.opb[XLEN-1]}}, md.opb};

    assign md.md_stall = md.md_start && func_ok && busy;
    assign md.busy     = busy;
    assign md.done     = done_q;
    assign md.hi       = hi_q;
    assign md.lo       = lo_q;

    md_div_step u_step (
        .rem     (rem),
        .dvd     (dvd),
        .dsr     (dsr),
        .rem_nxt (step_rem),
        .dvd_nxt (step_dvd),
        .q_bit   (step_q)
    );

    always_comb begin
        nxt_state = state;
        nxt_cnt   = cnt;
        nxt_prod  = prod;
        nxt_rem   = rem;
        nxt_dvd   = dvd;
        nxt_dsr   = dsr;
        nxt_neg_q = neg_q;
        nxt_neg_r = neg_r;
        nxt_dz    = dz;
        nxt_hi    = hi_q;
        nxt_lo    = lo_q;
        nxt_done  = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    unique case (md.md_func)
                        MD_MULT: begin
                            nxt_prod  = ext_a * ext_b;
                            nxt_cnt   = 6'd1;
                            nxt_state = MUL;
                        end
                        MD_DIV: begin
                            nxt_rem   = '0;
                            nxt_dvd   = abs_a;
                            nxt_dsr   = abs_b;
                            nxt_neg_q = md.md_sign & (md.opa[XLEN-1] ^ md.opb[XLEN-1]);
                            nxt_neg_r = md.md_sign & md.opa[XLEN-1];
                            nxt_dz    = (md.opb == '0);
                            nxt_cnt   = '0;
                            nxt_state = DIV;
`ifdef MD_EARLY_OUT_EN
                            // Quotient is zero; hold FIX one extra cycle
                            if (abs_b > abs_a && md.opb != '0) begin
                                nxt_rem   = {1'b0, abs_a};
                                nxt_dvd   = '0;
                                nxt_cnt   = 6'd1;
                                nxt_state = FIX;
                            end
`endif
                        end
                        MD_MTHI: nxt_hi = md.opa;
                        MD_MTLO: nxt_lo = md.opa;
                        default: ;
                    endcase
                end
            end
            MUL: begin
                if (cnt == 6'(MUL_LAT)) begin
                    {nxt_hi, nxt_lo} = prod;
                    nxt_done  = 1'b1;
                    nxt_cnt   = '0;
                    nxt_state = IDLE;
                end else begin
                    nxt_cnt = cnt + 6'd1;
                end
            end
            DIV: begin
                nxt_rem = step_rem;
                nxt_dvd = step_dvd | {{(XLEN-1){1'b0}}, step_q};
                if (cnt == 6'(DIV_STEPS-1)) begin
                    nxt_cnt   = '0;
                    nxt_state = FIX;
                end else begin
                    nxt_cnt = cnt + 6'd1;
                end
            end
            FIX: begin
                if (cnt != '0) begin
                    nxt_cnt = cnt - 6'd1;
                end else begin
                    // Zero divisor: remainder magnitude re-signed equals opa
                    nxt_lo    = dz ? '1 : (neg_q ? -dvd : dvd);
                    nxt_hi    = neg_r ? -rem[XLEN-1:0] : rem[XLEN-1:0];
                    nxt_done  = 1'b1;
                    nxt_state = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            prod   <= '0;
            rem    <= '0;
            dvd    <= '0;
            dsr    <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            dz     <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
        end else begin
            state  <= nxt_state;
            cnt    <= nxt_cnt;
            prod   <= nxt_prod;
            rem    <= nxt_rem;
            dvd    <= nxt_dvd;
            dsr    <= nxt_dsr;
            neg_q  <= nxt_neg_q;
            neg_r  <= nxt_neg_r;
            dz     <= nxt_dz;
            hi_q   <= nxt_hi;
            lo_q   <= nxt_lo;
            done_q <= nxt_done;
        end
    end

endmodule

// File: tb/tb_md_unit_ctrl.sv
// Self-checking bench for md_unit_ctrl: directed cases plus random traffic
// compared every cycle against an arithmetic reference model.
module tb_md_unit_ctrl;
    import md_pkg::*;

    localparam int MUL_LAT = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    md_unit_ctrl_if bus ();

    md_unit_ctrl #(.MUL_LAT(MUL_LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .md    (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    int          m_left = 0;
    logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
    logic        m_done = 1'b0;

    function automatic logic func_ok(input md_func_t f);
        return f inside {MD_MULT, MD_DIV, MD_MTHI, MD_MTLO, MD_MFHI, MD_MFLO};
    endfunction

    function automatic logic [63:0] mul_ref(input logic [31:0] a, b, input logic s);
        longint pa, pb;
        if (s) begin
            pa = longint'($signed(a));
            pb = longint'($signed(b));
        end else begin
            pa = longint'({32'b0, a});
            pb = longint'({32'b0, b});
        end
        return 64'(pa * pb);
    endfunction

    // Returns {remainder, quotient}
    function automatic logic [63:0] div_ref(input logic [31:0] a, b, input logic s);
        int sa, sb;
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (!s) return {a % b, a / b};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        sa = $signed(a);
        sb = $signed(b);
        return {32'(sa % sb), 32'(sa / sb)};
    endfunction

    function automatic int div_lat(input logic [31:0] a, b, input logic s);
`ifdef MD_EARLY_OUT_EN
        logic [31:0] ma, mb;
        ma = (s && a[31]) ? -a : a;
        mb = (s && b[31]) ? -b : b;
        if (b != 0 && mb > ma) return 2;
`endif
        return 33;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left <= 0;
            m_hi   <= '0;
            m_lo   <= '0;
            p_hi   <= '0;
            p_lo   <= '0;
            m_done <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (m_left > 0) begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_hi   <= p_hi;
                    m_lo   <= p_lo;
                    m_done <= 1'b1;
                end
            end else if (bus.md_start && !bus.ex_flush && func_ok(bus.md_func)) begin
                case (bus.md_func)
                    MD_MULT: begin
                        {p_hi, p_lo} <= mul_ref(bus.opa, bus.opb, bus.md_sign);
                        m_left <= MUL_LAT;
                    end
                    MD_DIV: begin
                        {p_hi, p_lo} <= div_ref(bus.opa, bus.opb, bus.md_sign);
                        m_left <= div_lat(bus.opa, bus.opb, bus.md_sign);
                    end
                    MD_MTHI: m_hi <= bus.opa;
                    MD_MTLO: m_lo <= bus.opa;
                    default: ;
                endcase
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        logic es;
        es = bus.md_start && func_ok(bus.md_func) && (m_left > 0);
        chk("busy",  32'(bus.busy),     32'(m_left > 0));
        chk("done",  32'(bus.done),     32'(m_done));
        chk("stall", 32'(bus.md_stall), 32'(es));
        chk("hi",    bus.hi,            m_hi);
        chk("lo",    bus.lo,            m_lo);
    endtask

    task automatic tick();
        @(negedge clk);
        check_all();
        @(posedge clk);
        #2;
    endtask

    task automatic set_idle();
        bus.md_start = 1'b0;
        bus.md_func  = MD_NONE;
        bus.md_sign  = 1'b0;
        bus.opa      = '0;
        bus.opb      = '0;
        bus.ex_flush = 1'b0;
    endtask

    task automatic issue(input md_func_t f, input logic s, input logic [31:0] a, b,
                         output int waited);
        logic busy_b4;
        bus.md_start = 1'b1;
        bus.md_func  = f;
        bus.md_sign  = s;
        bus.opa      = a;
        bus.opb      = b;
        bus.ex_flush = 1'b0;
        waited = 0;
        do begin
            busy_b4 = (m_left > 0);
            tick();
            waited++;
        end while (busy_b4 && waited < 200);
        if (busy_b4) begin
            n_tests++;
            n_fail++;
            $display("FAIL issue_timeout: waited %0d cycles", waited);
        end
        set_idle();
    endtask

    task automatic wait_idle();
        int k = 0;
        while (m_left > 0 && k < 100) begin
            tick();
            k++;
        end
        n_tests++;
        if (m_left > 0) begin
            n_fail++;
            $display("FAIL idle_timeout: still busy after %0d cycles", k);
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int w;
        int bcnt, dcnt;
        set_idle();
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_hi", bus.hi, 32'h0);
        chk("rst_lo", bus.lo, 32'h0);
        chk("rst_busy", 32'(bus.busy), 32'h0);
        chk("rst_done", 32'(bus.done), 32'h0);
        rst_n = 1'b1;
        tick();

        issue(MD_MTHI, 1'b0, 32'h1234_5678, 32'h0, w);
        chk("mthi_hi", bus.hi, 32'h1234_5678);
        issue(MD_MFHI, 1'b0, 32'h0, 32'h0, w);
        chk("mfhi_wait", 32'(w), 32'd1);

        issue(MD_MULT, 1'b1, 32'hFFFF_FFFE, 32'd3, w);
        bcnt = 0;
        dcnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus.busy) bcnt++;
            if (bus.done) dcnt++;
            tick();
        end
        chk("mult_busy_cycles", 32'(bcnt), 32'd4);
        chk("mult_done_pulses", 32'(dcnt), 32'd1);
        chk("mult_hi", bus.hi, 32'hFFFF_FFFF);
        chk("mult_lo", bus.lo, 32'hFFFF_FFFA);

        issue(MD_DIV, 1'b1, -32'sd7, 32'd2, w);
        issue(MD_MFLO, 1'b0, 32'h0, 32'h0, w);
        chk("div_mflo_wait", 32'(w), 32'd34);
        chk("div_lo", bus.lo, 32'hFFFF_FFFD);
        chk("div_hi", bus.hi, 32'hFFFF_FFFF);

        issue(MD_DIV, 1'b0, 32'd100, 32'd0, w);
        repeat (32) tick();
        chk("dz_busy_e32", 32'(bus.busy), 32'd1);
        chk("dz_lo_e32", bus.lo, 32'hFFFF_FFFD);
        tick();
        chk("dz_lo", bus.lo, 32'hFFFF_FFFF);
        chk("dz_hi", bus.hi, 32'd100);
        chk("dz_done", 32'(bus.done), 32'd1);

        issue(MD_DIV, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, w);
        wait_idle();
        tick();
        chk("ovf_lo", bus.lo, 32'h8000_0000);
        chk("ovf_hi", bus.hi, 32'h0);

        issue(MD_DIV, 1'b0, 32'd1000, 32'd7, w);
        repeat (4) tick();
        bus.md_start = 1'b1;
        bus.md_func  = MD_MTHI;
        bus.opa      = 32'hDEAD_BEEF;
        bus.ex_flush = 1'b1;
        tick();
        set_idle();
        wait_idle();
        tick();
        chk("flush_lo", bus.lo, 32'd142);
        chk("flush_hi", bus.hi, 32'd6);
        bus.md_start = 1'b1;
        bus.md_func  = MD_MTLO;
        bus.opa      = 32'h55;
        bus.ex_flush = 1'b1;
        tick();
        set_idle();
        tick();
        chk("flush_idle_lo", bus.lo, 32'd142);

`ifdef MD_EARLY_OUT_EN
        issue(MD_DIV, 1'b0, 32'd3, 32'd10, w);
        chk("early_busy_e1", 32'(bus.busy), 32'd1);
        tick();
        chk("early_busy_e2", 32'(bus.busy), 32'd1);
        tick();
        chk("early_lo", bus.lo, 32'd0);
        chk("early_hi", bus.hi, 32'd3);
        chk("early_done", 32'(bus.done), 32'd1);
`endif

        issue(MD_DIV, 1'b1, -32'sd100, 32'd7, w);
        repeat (9) tick();
        rst_n = 1'b0;
        #1;
        chk("midrst_hi", bus.hi, 32'h0);
        chk("midrst_lo", bus.lo, 32'h0);
        chk("midrst_busy", 32'(bus.busy), 32'h0);
        chk("midrst_done", 32'(bus.done), 32'h0);
        tick();
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 3000; i++) begin
            bus.md_start = ($urandom_range(0, 3) != 0);
            bus.md_func  = md_func_t'(3'($urandom_range(0, 7)));
            bus.md_sign  = 1'($urandom_range(0, 1));
            bus.opa      = pick();
            bus.opb      = pick();
            bus.ex_flush = ($urandom_range(0, 7) == 0);
            tick();
        end
        set_idle();
        wait_idle();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
